// File: rtl/bus_arbiter_if.sv
// Bus-ownership handshake bundle: request/lock from the sources, grant and
// driver-select information back from the arbiter.
interface bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 24,
  parameter int unsigned SEL_W   = 5
);
  logic [NUM_REQ-1:0] req;
  logic               lock;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   bus_sel;
  logic               bus_busy;
  logic               handover;

  // Requester side
  modport master (
    output req, lock,
    input  grant, bus_sel, bus_busy, handover
  );

  // Arbiter side
  modport slave (
    input  req, lock,
    output grant, bus_sel, bus_busy, handover
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal 32-bit bus. Grants one source at a time,
// bounds each owner's tenure while others wait, and lets a lock hold the
// current owner through multi-cycle atomic transfers.
module bus_arbiter #(
  parameter int unsigned NUM_REQ    = 24,
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned MAX_TENURE = 4
) (
  input logic           clk,
  input logic           clear,
  bus_arbiter_if.slave  bus
);

  localparam logic [3:0]       TenMax  = 4'(MAX_TENURE);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             r_state;
  logic [3:0]         r_tenure;
  logic [SEL_W-1:0]   r_last;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_busy;
  logic               r_handover;

  logic [NUM_REQ-1:0] w_req;
  logic               w_owner_req;
  logic               w_others;
  logic               w_pick_vld;
  logic [SEL_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_pick_hot;

  assign w_req       = bus.req;
  assign w_owner_req = |(w_req & r_grant);
  assign w_others    = |(w_req & ~r_grant);
  assign w_pick_hot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;

  // Round-robin search starting just after the last owner; the owner itself
  // is visited last, so it only wins when nobody else is asking.
  always_comb begin : p_pick
    int unsigned idx;
    idx        = 0;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_last) + k) % NUM_REQ;
      if (!w_pick_vld && w_req[idx[SEL_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = idx[SEL_W-1:0];
      end
    end
  end

  // Ownership FSM with registered grant, select, busy and handover outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= StIdle;
      r_tenure   <= '0;
      r_last     <= LastIdx;
      r_grant    <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_handover <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_handover <= 1'b0;
          if (w_pick_vld) begin
            r_state  <= StBusy;
            r_tenure <= 4'd1;
            r_last   <= w_pick;
            r_grant  <= w_pick_hot;
            r_sel    <= w_pick;
            r_busy   <= 1'b1;
          end
        end
        StBusy: begin
          if (!w_owner_req) begin
            // Release wins over lock and over tenure expiry.
            if (w_others) begin
              r_tenure   <= 4'd1;
              r_last     <= w_pick;
              r_grant    <= w_pick_hot;
              r_sel      <= w_pick;
              r_handover <= 1'b1;
            end else begin
              r_state    <= StIdle;
              r_tenure   <= '0;
              r_grant    <= '0;
              r_sel      <= '0;
              r_busy     <= 1'b0;
              r_handover <= 1'b0;
            end
          end else if (r_tenure >= TenMax && !bus.lock && w_others) begin
            r_tenure   <= 4'd1;
            r_last     <= w_pick;
            r_grant    <= w_pick_hot;
            r_sel      <= w_pick;
            r_handover <= 1'b1;
          end else begin
            r_handover <= 1'b0;
            if (r_tenure < TenMax) begin
              r_tenure <= r_tenure + 4'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.bus_sel  = r_sel;
  assign bus.bus_busy = r_busy;
  assign bus.handover = r_handover;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against an ownership model
// tracked as owner index / tenure count / last owner.
module tb_bus_arbiter;

  localparam int N  = 24;
  localparam int SW = 5;
  localparam int MT = 4;

  logic clk   = 1'b0;
  logic clear = 1'b0;

  bus_arbiter_if #(.NUM_REQ(N), .SEL_W(SW)) bif ();

  bus_arbiter #(.NUM_REQ(N), .SEL_W(SW), .MAX_TENURE(MT)) u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_owner  = -1;
  int m_tenure = 0;
  int m_last   = N - 1;
  int m_ho     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (from + k) % N;
      if (r[idx[4:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_last   = N - 1;
    m_ho     = 0;
  endtask

  task automatic model_take(input logic [N-1:0] r);
    m_owner  = rr_pick(r, m_last);
    m_last   = m_owner;
    m_tenure = 1;
    m_ho     = 1;
  endtask

  // One arbitration decision from the sampled req/lock.
  task automatic model_step();
    logic [N-1:0] r;
    logic [N-1:0] others;
    r = bif.req;
    if (m_owner < 0) begin
      m_ho = 0;
      if (r != '0) begin
        model_take(r);
        m_ho = 0;
      end
    end else begin
      others = r & ~(N'(1) << m_owner);
      if (!r[m_owner[4:0]]) begin
        if (others != '0) model_take(r);
        else begin
          m_owner  = -1;
          m_tenure = 0;
          m_ho     = 0;
        end
      end else if (m_tenure >= MT && !bif.lock && others != '0) begin
        model_take(r);
      end else begin
        m_ho = 0;
        if (m_tenure < MT) m_tenure++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
    check({tag, "_grant"}, 32'(bif.grant), eg);
    check({tag, "_sel"}, 32'(bif.bus_sel), (m_owner < 0) ? 32'h0 : 32'(m_owner));
    check({tag, "_busy"}, 32'(bif.bus_busy), (m_owner < 0) ? 32'h0 : 32'h1);
    check({tag, "_handover"}, 32'(bif.handover), 32'(m_ho));
    check({tag, "_onehot"}, 32'($countones(bif.grant) <= 1), 32'h1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_reset();
    #1;
    check_outputs("clr");
    #1;
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    bif.req  = '0;
    bif.lock = 1'b0;
    #2;

    // 1: reset then single request from PC
    do_clear();
    bif.req = N'(1) << 20;
    tick("t1a");
    check("t1_grant", 32'(bif.grant), 32'h0010_0000);
    check("t1_sel", 32'(bif.bus_sel), 32'd20);
    check("t1_busy", 32'(bif.bus_busy), 32'h1);
    bif.req = '0;
    tick("t1b");
    check("t1_idle", 32'(bif.bus_busy), 32'h0);

    // 2: round robin between R0 and R2 with bounded tenure
    do_clear();
    bif.req = N'(5);
    repeat (4) tick("t2a");
    check("t2_r0_held", 32'(bif.bus_sel), 32'd0);
    tick("t2b");
    check("t2_to_r2", 32'(bif.bus_sel), 32'd2);
    check("t2_ho", 32'(bif.handover), 32'h1);
    repeat (3) tick("t2c");
    check("t2_ho_pulse", 32'(bif.handover), 32'h0);
    tick("t2d");
    check("t2_back_r0", 32'(bif.bus_sel), 32'd0);
    check("t2_ho2", 32'(bif.handover), 32'h1);

    // 3: lock blocks preemption until it falls
    do_clear();
    bif.req = N'(1) << 5;
    tick("t3a");
    bif.lock = 1'b1;
    bif.req  = (N'(1) << 5) | (N'(1) << 9);
    repeat (12) tick("t3b");
    check("t3_locked", 32'(bif.bus_sel), 32'd5);
    bif.lock = 1'b0;
    tick("t3c");
    check("t3_preempt", 32'(bif.bus_sel), 32'd9);
    check("t3_ho", 32'(bif.handover), 32'h1);

    // 4: release wins over lock
    do_clear();
    bif.req = N'(1) << 3;
    tick("t4a");
    bif.lock = 1'b1;
    bif.req  = (N'(1) << 3) | (N'(1) << 7);
    repeat (6) tick("t4b");
    check("t4_locked", 32'(bif.bus_sel), 32'd3);
    bif.req = N'(1) << 7;
    tick("t4c");
    check("t4_release", 32'(bif.bus_sel), 32'd7);
    check("t4_ho", 32'(bif.handover), 32'h1);
    bif.lock = 1'b0;

    // 5: wrap-around after C was the last owner
    do_clear();
    bif.req = N'(1) << 23;
    tick("t5a");
    bif.req = '0;
    tick("t5b");
    bif.req = (N'(1) << 23) | N'(2);
    tick("t5c");
    check("t5_wrap", 32'(bif.bus_sel), 32'd1);

    // 6: asynchronous clear mid-transfer
    do_clear();
    bif.req = N'(1) << 21;
    tick("t6a");
    tick("t6b");
    #2;
    clear = 1'b1;
    model_reset();
    #1;
    check("t6_async_grant", 32'(bif.grant), 32'h0);
    check("t6_async_sel", 32'(bif.bus_sel), 32'h0);
    check("t6_async_busy", 32'(bif.bus_busy), 32'h0);
    #1;
    clear = 1'b0;
    tick("t6c");
    check("t6_regrant", 32'(bif.bus_sel), 32'd21);

    // Random traffic: sparse toggling of request bits, occasional lock
    do_clear();
    bif.req = '0;
    for (int i = 0; i < 400; i++) begin
      rnd      = $urandom & $urandom & $urandom;
      bif.req  = bif.req ^ rnd[N-1:0];
      bif.lock = ($urandom_range(0, 4) == 0);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that owns the internal 32-bit bus and its driver-select encoder.
- Up to 24 bus sources request the bus: R0–R15, HI, LO, ZHI, ZLO, PC, MDR, Inport and C, on request bits 0–23 in that order.
- Grants exactly one source per cycle, as a registered one-hot grant vector and its 5-bit index.
- Enforces a bounded tenure so that no source starves another, with a lock input for multi-cycle atomic transfers.

Parameters:
- NUM_REQ, 24: number of requesters; bits at index NUM_REQ and above do not exist.
- SEL_W, 5: width of bus_sel; must satisfy 2^SEL_W >= NUM_REQ.
- MAX_TENURE, 4: cycles an owner may hold the bus while others wait and lock=0; legal range 1–15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-source request level; held high while the source wants the bus.
- lock  input  1  when high, the current owner cannot be preempted.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when the bus is idle.
- bus_sel  output  SEL_W  binary index of the set grant bit; 0 when idle.
- bus_busy  output  1  high whenever any grant bit is set.
- handover  output  1  one-cycle pulse in any cycle where grant changes from one owner directly to another.

Behaviour:
- Reset (clear=1, asynchronous):
  - grant=0, bus_sel=0, bus_busy=0, handover=0.
  - State=IDLE, tenure=0, last_owner=NUM_REQ-1, so the first search starts at bit 0.
  - Asserting clear mid-transfer drops grant immediately, without waiting for a clock edge.
- Round-robin pick:
  - Scan requesters starting at last_owner+1 and wrap modulo NUM_REQ.
  - Take the first asserted req bit.
  - The current owner is considered last.
- State IDLE:
  - If req=0, remain in IDLE.
  - Otherwise, at the edge, grant the round-robin pick: state=BUSY, tenure=1, last_owner=pick, handover=0.
  - Latency is 1 cycle: req sampled high at edge N gives grant visible after edge N.
- State BUSY, evaluated at each edge in priority order:
  1. Owner's req=0 (release): if any other req is set, grant the pick, set tenure=1 and pulse handover. Otherwise grant=0 and go to IDLE. Release takes effect even when lock=1.
  2. tenure>=MAX_TENURE and lock=0 and another req is set (preempt): grant the pick, tenure=1, handover=1.
  3. Otherwise keep the owner. Tenure increments, saturating at MAX_TENURE.
- Tenure and lock:
  - With lock=1, tenure still counts but preemption is inhibited.
  - When lock falls with tenure already saturated and others waiting, preemption occurs at the next edge.
- Output invariants:
  - grant is never multi-hot.
  - bus_sel always equals the index of the set grant bit.
  - bus_busy equals the OR of grant.
  - All outputs are registered; none depend combinationally on req.
- Simultaneous events: if release and tenure expiry occur in the same cycle, the release rule applies. The result is identical; only the tenure reset path differs.
- A single requester with tenure expired and no competitor keeps the bus indefinitely, with tenure held at MAX_TENURE.
- Handover between two owners is back-to-back, with no idle cycle. The select encoder therefore sees a single driver every cycle.

Test Plan:
1. Reset then single request: clear pulse, then req=bit 20 (PC) → one edge later grant=0x100000, bus_sel=20, bus_busy=1, handover=0. Drop req → next edge grant=0, bus_busy=0.
2. Round-robin order: hold req=0x000005 (R0, R2) with MAX_TENURE=4 → grant R0 for 4 cycles, then R2 for 4 cycles, then R0 again. Each switch pulses handover for 1 cycle, and bus_sel alternates 0→2→0.
3. Lock blocks preemption: R5 is owner with lock=1 and req also has R9 set → R5 is held for 10+ cycles. Deassert lock → next edge bus_sel=9, handover=1.
4. Release beats lock: R3 owns with lock=1, R7 waiting; drop req[3] → next edge bus_sel=7, handover=1.
5. Wrap-around: last_owner=23 (C), req=bits 23 and 1 → next pick is R1 (bus_sel=1), not C.
6. Async clear mid-transfer: owner MDR (21) at tenure 2; assert clear between edges → grant=0 and bus_sel=0 without any clock edge. After release, req=bit 21 → granted at bit 21, with the scan starting from 0.
